// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_add_pkg;

   localparam int WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full adder; the only arithmetic element of the serial adder.
module FA (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: computes a+b+cin one bit per clock, LSB first, through a
// single shared full adder. Results are published only when the last bit has
// been processed, so an aborted run never disturbs sum/cout/ovf.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] opa_q, opb_q, acc_q;
   logic             carry_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q, ovf_q;

   logic             fa_sum, fa_cout;
   logic             accept, last_bit;
   logic [WIDTH-1:0] acc_d;

   assign accept   = (state_q == IDLE) && start;
   assign last_bit = (state_q == RUN) && (cnt_q == LAST);
   // Shift the fresh sum bit in at the top; the full-width shift reads every bit.
   assign acc_d    = WIDTH'({fa_sum, acc_q} >> 1);

   FA u_fa (
      .a    (opa_q[0]),
      .b    (opb_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; start is only looked at in IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)    state_d = RUN;
         RUN:     if (last_bit) state_d = DONE;
         DONE:                  state_d = IDLE;
         default:               state_d = IDLE;
      endcase
   end

   // Moore status outputs, one-hot over the three states
   always_comb begin
      ready = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      case (state_q)
         IDLE:    ready = 1'b1;
         RUN:     busy  = 1'b1;
         DONE:    done  = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   // Serial datapath: load on accept, one bit per RUN edge, publish on last bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         opa_q   <= a;
         opb_q   <= b;
         carry_q <= cin;
         cnt_q   <= '0;
      end else if (state_q == RUN) begin
         opa_q   <= opa_q >> 1;
         opb_q   <= opb_q >> 1;
         acc_q   <= acc_d;
         carry_q <= fa_cout;
         // Counter parks at terminal count instead of wrapping
         if (!last_bit) cnt_q <= cnt_q + 1'b1;
         if (last_bit) begin
            sum_q  <= acc_d;
            cout_q <= fa_cout;
            // carry_q is the carry into the MSB at this point
            ovf_q  <= carry_q ^ fa_cout;
         end
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks for the bit-serial adder controller (WIDTH=32).
module tb_serial_add_ctrl;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a, b;
   logic         cin;
   logic         ready, busy, done;
   logic [W-1:0] sum;
   logic         cout, ovf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   // Launch one operation and return the edge number (acceptance = 1) at which
   // done was observed; -1 if never ready, >=100 if done never came.
   task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, output int edges);
      edges = -1;
      for (int i = 0; i < 100 && !ready; i++) begin
         @(posedge clk); #1;
      end
      if (!ready) return;
      a = ia; b = ib; cin = ic; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      edges = 1;
      while (!done && edges < 100) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      #2;
      checks++;
      if ({ready, busy, done} !== 3'b100) begin
         errors++;
         $display("FAIL reset_status: got rdy/busy/done=%b expected 100", {ready, busy, done});
      end
      checks++;
      if (sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_result: got sum=%h cout=%b ovf=%b expected 0/0/0", sum, cout, ovf);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_vectors();
      logic [W-1:0] va [4] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
      logic [W-1:0] vb [4] = '{32'h0000_0001, 32'h0000_0000, 32'h8000_0000, 32'h0000_0001};
      logic         vc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [W-1:0] es [4] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000};
      logic         eco[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic         eov[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      int edges;
      for (int i = 0; i < 4; i++) begin
         do_op(va[i], vb[i], vc[i], edges);
         checks++;
         if (edges !== 33) begin
            errors++;
            $display("FAIL vec%0d_latency: done at edge %0d expected 33", i, edges);
         end
         checks++;
         if (sum !== es[i] || cout !== eco[i] || ovf !== eov[i]) begin
            errors++;
            $display("FAIL vec%0d_result: got sum=%h cout=%b ovf=%b expected %h/%b/%b",
                     i, sum, cout, ovf, es[i], eco[i], eov[i]);
         end
         @(posedge clk); #1;
         checks++;
         if (ready !== 1'b1 || sum !== es[i]) begin
            errors++;
            $display("FAIL vec%0d_idle_hold: got ready=%b sum=%h expected 1/%h", i, ready, sum, es[i]);
         end
      end
   endtask

   // Extra start pulses in RUN and DONE must be ignored; operands may change.
   task automatic test_ignore_start();
      int n, dcount, dn;
      for (int i = 0; i < 100 && !ready; i++) begin
         @(posedge clk); #1;
      end
      a = 32'd5; b = 32'd7; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = 32'd100; b = 32'd100; cin = 1'b1;
      n = 1; dcount = 0; dn = 0;
      while (n < 40) begin
         start = (n == 11) || done;
         @(posedge clk); #1;
         n++;
         if (done) begin dcount++; dn = n; end
         if (n == 20) begin
            checks++;
            if (busy !== 1'b1 || sum !== 32'h8000_0000) begin
               errors++;
               $display("FAIL ign_midrun: got busy=%b sum=%h expected 1/80000000", busy, sum);
            end
         end
         if (n == 34) begin
            checks++;
            if (ready !== 1'b1) begin
               errors++;
               $display("FAIL ign_ready_after_done: got ready=%b expected 1", ready);
            end
         end
      end
      start = 1'b0;
      checks++;
      if (dcount !== 1 || dn !== 33) begin
         errors++;
         $display("FAIL ign_done_pulse: got count=%0d edge=%0d expected 1/33", dcount, dn);
      end
      checks++;
      if (sum !== 32'd12 || cout !== 1'b0 || ovf !== 1'b0 || ready !== 1'b1) begin
         errors++;
         $display("FAIL ign_result: got sum=%0d cout=%b ovf=%b ready=%b expected 12/0/0/1",
                  sum, cout, ovf, ready);
      end
   endtask

   task automatic test_reset_abort();
      int edges;
      bit saw_done;
      for (int i = 0; i < 100 && !ready; i++) begin
         @(posedge clk); #1;
      end
      a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (16) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      checks++;
      if ({ready, busy, done} !== 3'b100 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL abort_async: got rdy/busy/done=%b sum=%h cout=%b ovf=%b expected 100/0/0/0",
                  {ready, busy, done}, sum, cout, ovf);
      end
      saw_done = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      rst = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      checks++;
      if (saw_done !== 1'b0 || sum !== '0) begin
         errors++;
         $display("FAIL abort_no_done: got done_seen=%b sum=%h expected 0/0", saw_done, sum);
      end
      do_op(32'd3, 32'd4, 1'b0, edges);
      checks++;
      if (edges !== 33 || sum !== 32'd7) begin
         errors++;
         $display("FAIL abort_restart: got edge=%0d sum=%0d expected 33/7", edges, sum);
      end
   endtask

   // start held high: second operation accepted WIDTH+2 edges after the first.
   task automatic test_back_to_back();
      int n, d1, d2;
      for (int i = 0; i < 100 && !ready; i++) begin
         @(posedge clk); #1;
      end
      a = 32'd10; b = 32'd20; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      a = 32'd1000; b = 32'd2000;
      n = 1; d1 = 0; d2 = 0;
      while (n < 75) begin
         @(posedge clk); #1;
         n++;
         if (n == 35) start = 1'b0;
         if (done && d1 == 0) begin
            d1 = n;
            checks++;
            if (sum !== 32'd30) begin
               errors++;
               $display("FAIL b2b_first_sum: got %0d expected 30", sum);
            end
         end else if (done && d2 == 0) begin
            d2 = n;
            checks++;
            if (sum !== 32'd3000) begin
               errors++;
               $display("FAIL b2b_second_sum: got %0d expected 3000", sum);
            end
         end
         if (n == 34) begin
            checks++;
            if (ready !== 1'b1) begin
               errors++;
               $display("FAIL b2b_ready: got ready=%b expected 1", ready);
            end
         end
         if (n == 35) begin
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL b2b_reaccept: got busy=%b expected 1", busy);
            end
         end
      end
      checks++;
      if (d1 !== 33 || d2 !== 67) begin
         errors++;
         $display("FAIL b2b_timing: got done edges %0d,%0d expected 33,67", d1, d2);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] ra, rb, es;
      logic         rc, eco, eov;
      logic [W:0]   full;
      int edges;
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
         full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         es   = full[W-1:0];
         eco  = full[W];
         eov  = (ra[W-1] == rb[W-1]) && (es[W-1] != ra[W-1]);
         do_op(ra, rb, rc, edges);
         checks++;
         if (edges !== 33 || sum !== es || cout !== eco || ovf !== eov) begin
            errors++;
            $display("FAIL rand%0d: a=%h b=%h cin=%b got edge=%0d sum=%h cout=%b ovf=%b expected 33/%h/%b/%b",
                     i, ra, rb, rc, edges, sum, cout, ovf, es, eco, eov);
         end
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
